mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single memory port between the instruction-fetch unit (IFU) and the load/store unit (LSU).
- Replaces the direct per-cycle memory read in the fetch path once fetch becomes multi-cycle.
- Accepts one request at a time, holds it on the memory side until accepted, and routes the response back to the requester that issued it.
- Sits between IFU/LSU and the memory model or bus bridge.

Parameters:
WIDTH, 32, address/data width
MASK_W, WIDTH/8, write byte-mask width

Ports:
clk  input  1  clock
rst  input  1  reset; synchronous, active-high
IFU_i_req_valid  input  1  fetch request valid
IFU_o_req_ready  output  1  fetch request accepted this cycle
IFU_i_addr  input  WIDTH  fetch address (PC)
IFU_o_resp_valid  output  1  instruction returned this cycle
IFU_o_rdata  output  WIDTH  instruction word
LSU_i_req_valid  input  1  load/store request valid
LSU_o_req_ready  output  1  load/store request accepted this cycle
LSU_i_addr  input  WIDTH  data address
LSU_i_wen  input  1  1 = store, 0 = load
LSU_i_wdata  input  WIDTH  store data
LSU_i_wmask  input  MASK_W  store byte mask
LSU_o_resp_valid  output  1  load data / store ack this cycle
LSU_o_rdata  output  WIDTH  load data
MEM_o_req_valid  output  1  memory request valid
MEM_i_req_ready  input  1  memory accepts request
MEM_o_addr  output  WIDTH  latched address
MEM_o_wen  output  1  latched write enable
MEM_o_wdata  output  WIDTH  latched write data
MEM_o_wmask  output  MASK_W  latched mask; 0 for reads
MEM_i_resp_valid  input  1  memory response valid
MEM_i_rdata  input  WIDTH  memory read data

Behaviour:

FSM states: IDLE, REQ, WAIT. One outstanding transaction maximum.

IDLE:
- If any i_req_valid, pick a winner (see priority below).
- Winner's o_req_ready = 1 combinationally in that cycle; handshake occurs there.
- On handshake: latch addr/wen/wdata/wmask into the MEM_o_* registers and the owner register; go to REQ.
- IFU requests latch wen = 0 and wmask = 0.

REQ:
- MEM_o_req_valid = 1; the MEM_o_* fields stay stable.
- On MEM_i_req_ready: go to WAIT. Otherwise stay in REQ indefinitely (no timeout).

WAIT:
- On MEM_i_resp_valid: owner's o_resp_valid = 1 and o_rdata = MEM_i_rdata, combinationally in the same cycle. Go to IDLE.
- Non-owner o_resp_valid stays 0.

General rules:
- Both o_req_ready are 0 outside IDLE. Requesters hold valid and payload until ready.
- Requesters always sink a response; there is no response backpressure.
- Default priority is fixed: LSU over IFU. This lets the in-flight instruction's data access complete before the next fetch.
- Minimum latency, request to response: 3 cycles (IDLE handshake, REQ with ready, WAIT with resp_valid).
- Memory guarantees the response arrives at least 1 cycle after its request handshake.
- MEM_i_resp_valid outside WAIT is ignored; no output changes.
- Store responses are acks: LSU_o_resp_valid = 1, and LSU_o_rdata is passed through but undefined.
- o_rdata outputs are 0 whenever their resp_valid is 0.
- Reset:
  - State returns to IDLE, owner = IFU, all MEM_o_* registers = 0.
  - All valid/ready outputs are 0 in the reset cycle.
  - Reset during REQ/WAIT abandons the transaction, and no response is forwarded afterwards. Memory is reset by the same rst.
- A request arriving in the same cycle a response completes is not accepted until the following IDLE cycle; there is no IDLE bypass.

Optional Feature:
MEM_ARB_RR_EN
- Defined: round-robin arbitration. A last_owner register is updated on each completed response. On simultaneous requests in IDLE, the requester that is not last_owner wins. last_owner resets to LSU, so IFU wins first.
- Undefined: fixed LSU-over-IFU priority; no last_owner register.

Decomposition:
- Package mem_arb_pkg:
  - arb_state_e {IDLE, REQ, WAIT}
  - arb_owner_e {OWN_IFU, OWN_LSU}
  - WIDTH default constant
- One natural sub-module, arb_pick: combinational winner selection from the two valids plus last_owner, including the MEM_ARB_RR_EN variant. Everything else stays in mem_port_arbiter.

Test Plan:
- IFU-only fetch: IFU addr 0x80000000, MEM_i_req_ready = 1, response 0x00100073 two cycles later -> IFU_o_req_ready at cycle 0, MEM_o_req_valid at cycle 1, IFU_o_resp_valid with rdata 0x00100073 at cycle 2; LSU outputs stay 0.
- Simultaneous requests (default): IFU 0x80000004 and LSU load 0x80001000 in the same cycle -> LSU granted first, MEM_o_addr = 0x80001000; IFU granted in the IDLE after the LSU response.
- Memory backpressure: hold MEM_i_req_ready = 0 for 5 cycles on an LSU store (wdata 0xDEADBEEF, wmask 0xF) -> MEM_o_* stable for all 5 cycles; a single LSU_o_resp_valid after the ack.
- Stray response: MEM_i_resp_valid pulsed in IDLE -> no resp_valid on either side, state stays IDLE.
- Reset in WAIT: rst in the WAIT cycle, then MEM_i_resp_valid next cycle -> all outputs 0, state IDLE, no response forwarded.
- MEM_ARB_RR_EN: both requesters valid continuously for 4 transactions -> grant order IFU, LSU, IFU, LSU.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the IFU/LSU memory port arbiter.
package mem_arb_pkg;

  localparam int WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } arb_state_e;

  typedef enum logic {
    OWN_IFU,
    OWN_LSU
  } arb_owner_e;

endpackage

// File: rtl/arb_pick.sv
// Winner select between IFU and LSU; LSU-first, or alternating when MEM_ARB_RR_EN is defined.
// Purely combinational, zero latency; grants are qualified by the caller's FSM state.
module arb_pick (
  input  logic                   ifu_vld,
  input  logic                   lsu_vld,
`ifdef MEM_ARB_RR_EN
  input  mem_arb_pkg::arb_owner_e last_owner,
`endif
  output logic                   grant_ifu,
  output logic                   grant_lsu
);

  always_comb begin
    grant_lsu = lsu_vld;
    grant_ifu = ifu_vld && !lsu_vld;
`ifdef MEM_ARB_RR_EN
    // On a tie the requester that was not served last goes first.
    if (ifu_vld && lsu_vld) begin
      grant_ifu = (last_owner == mem_arb_pkg::OWN_LSU);
      grant_lsu = !grant_ifu;
    end
`endif
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between IFU and LSU, one transaction in flight (optional MEM_ARB_RR_EN).
// Latency >= 3 cycles: IDLE grant, REQ until MEM_i_req_ready, WAIT until MEM_i_resp_valid.
module mem_port_arbiter #(
  parameter int WIDTH  = mem_arb_pkg::WIDTH,
  parameter int MASK_W = WIDTH / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              IFU_i_req_valid,
  output logic              IFU_o_req_ready,
  input  logic [WIDTH-1:0]  IFU_i_addr,
  output logic              IFU_o_resp_valid,
  output logic [WIDTH-1:0]  IFU_o_rdata,
  input  logic              LSU_i_req_valid,
  output logic              LSU_o_req_ready,
  input  logic [WIDTH-1:0]  LSU_i_addr,
  input  logic              LSU_i_wen,
  input  logic [WIDTH-1:0]  LSU_i_wdata,
  input  logic [MASK_W-1:0] LSU_i_wmask,
  output logic              LSU_o_resp_valid,
  output logic [WIDTH-1:0]  LSU_o_rdata,
  output logic              MEM_o_req_valid,
  input  logic              MEM_i_req_ready,
  output logic [WIDTH-1:0]  MEM_o_addr,
  output logic              MEM_o_wen,
  output logic [WIDTH-1:0]  MEM_o_wdata,
  output logic [MASK_W-1:0] MEM_o_wmask,
  input  logic              MEM_i_resp_valid,
  input  logic [WIDTH-1:0]  MEM_i_rdata
);

  import mem_arb_pkg::*;

  arb_state_e        state_q, state_d;
  arb_owner_e        owner_q;
  logic [WIDTH-1:0]  addr_q, wdata_q;
  logic              wen_q;
  logic [MASK_W-1:0] wmask_q;
  logic              grant_ifu, grant_lsu;
  logic              resp_done;

`ifdef MEM_ARB_RR_EN
  arb_owner_e        last_owner_q;
`endif

  arb_pick u_pick (
    .ifu_vld    (IFU_i_req_valid),
    .lsu_vld    (LSU_i_req_valid),
`ifdef MEM_ARB_RR_EN
    .last_owner (last_owner_q),
`endif
    .grant_ifu  (grant_ifu),
    .grant_lsu  (grant_lsu)
  );

  assign MEM_o_addr  = addr_q;
  assign MEM_o_wen   = wen_q;
  assign MEM_o_wdata = wdata_q;
  assign MEM_o_wmask = wmask_q;
  assign resp_done   = (state_q == WAIT) && MEM_i_resp_valid;

  // Every handshake/valid output is masked during rst so the reset cycle is quiet.
  always_comb begin
    state_d          = state_q;
    IFU_o_req_ready  = 1'b0;
    LSU_o_req_ready  = 1'b0;
    MEM_o_req_valid  = 1'b0;
    IFU_o_resp_valid = 1'b0;
    LSU_o_resp_valid = 1'b0;
    IFU_o_rdata      = '0;
    LSU_o_rdata      = '0;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          IFU_o_req_ready = grant_ifu;
          LSU_o_req_ready = grant_lsu;
          if (grant_ifu || grant_lsu) state_d = REQ;
        end
        REQ: begin
          MEM_o_req_valid = 1'b1;
          if (MEM_i_req_ready) state_d = WAIT;
        end
        WAIT: begin
          if (MEM_i_resp_valid) begin
            state_d = IDLE;
            if (owner_q == OWN_LSU) begin
              LSU_o_resp_valid = 1'b1;
              LSU_o_rdata      = MEM_i_rdata;
            end else begin
              IFU_o_resp_valid = 1'b1;
              IFU_o_rdata      = MEM_i_rdata;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= OWN_IFU;
      addr_q       <= '0;
      wen_q        <= 1'b0;
      wdata_q      <= '0;
      wmask_q      <= '0;
`ifdef MEM_ARB_RR_EN
      last_owner_q <= OWN_LSU;
`endif
    end else begin
      state_q <= state_d;
      if (LSU_o_req_ready) begin
        owner_q <= OWN_LSU;
        addr_q  <= LSU_i_addr;
        wen_q   <= LSU_i_wen;
        wdata_q <= LSU_i_wdata;
        wmask_q <= LSU_i_wen ? LSU_i_wmask : '0;
      end else if (IFU_o_req_ready) begin
        owner_q <= OWN_IFU;
        addr_q  <= IFU_i_addr;
        wen_q   <= 1'b0;
        wdata_q <= '0;
        wmask_q <= '0;
      end
`ifdef MEM_ARB_RR_EN
      if (resp_done) last_owner_q <= owner_q;
`endif
    end
  end

endmodule
